// File: rtl/weight_fifo_loader.sv
// Weight FIFO write-side loader: fetches FIFO_DEPTH rows from the weight SRAM
// and shifts them into the weight FIFO one row per granted read, in address order.
module weight_fifo_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [FIFO_WIDTH-1:0] col_mask,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic [DATA_WIDTH-1:0] mem_rdata [0:FIFO_WIDTH-1],
  output logic [FIFO_WIDTH-1:0] en,
  output logic [DATA_WIDTH-1:0] w_out [0:FIFO_WIDTH-1]
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CNT_W-1:0]      req_cnt;
  logic [CNT_W-1:0]      push_cnt;
  logic [CNT_W-1:0]      req_inc;
  logic [CNT_W-1:0]      push_inc;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [FIFO_WIDTH-1:0] mask_q;
  logic                  accept;
  logic                  issue_p0;
  logic                  rd_vld_p1;

  assign accept   = (state == S_IDLE) && start;
  assign mem_re   = (state == S_LOAD);
  assign issue_p0 = mem_re && mem_gnt;
  assign req_inc  = req_cnt + 1'b1;
  assign push_inc = push_cnt + 1'b1;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  // Address wraps modulo 2^ADDR_WIDTH; forced to zero whenever no read is requested.
  assign mem_addr = mem_re ? (base_q + ADDR_WIDTH'(req_cnt)) : '0;

  // Next-state: leave LOAD on the last issue so mem_re drops the following cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (issue_p0 && (req_inc == DEPTH_C)) state_nxt = S_DRAIN;
      S_DRAIN: if ((rd_vld_p1 && (push_inc == DEPTH_C)) || (push_cnt == DEPTH_C))
                 state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM, request/push counters and the read-valid pipeline bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      req_cnt   <= '0;
      push_cnt  <= '0;
      rd_vld_p1 <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_vld_p1 <= issue_p0;
      if (accept) begin
        req_cnt  <= '0;
        push_cnt <= '0;
      end else begin
        if (issue_p0)  req_cnt  <= req_inc;
        if (rd_vld_p1) push_cnt <= push_inc;
      end
    end
  end

  // Load parameters captured once per accepted start; later changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      base_q <= base_addr;
      mask_q <= col_mask;
    end
  end

  // Stage p1: returned SRAM row goes straight to the FIFO input in the same cycle.
  always_comb begin
    en = rd_vld_p1 ? mask_q : '0;
    for (int i = 0; i < FIFO_WIDTH; i++) begin
      w_out[i] = rd_vld_p1 ? mem_rdata[i] : '0;
    end
  end

endmodule

// File: tb/tb_weight_fifo_loader.sv
// Scoreboard bench for weight_fifo_loader: expected issues/pushes/done queued by
// the stimulus, popped and compared by an independent monitor on the falling edge.
module tb_weight_fifo_loader;
  localparam int DW = 16;
  localparam int FW = 16;
  localparam int FD = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [FW-1:0] col_mask;
  logic          busy, done, mem_re, mem_gnt;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata [0:FW-1];
  logic [FW-1:0] en;
  logic [DW-1:0] w_out [0:FW-1];

  weight_fifo_loader #(.DATA_WIDTH(DW), .FIFO_WIDTH(FW), .FIFO_DEPTH(FD), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .col_mask(col_mask),
    .busy(busy), .done(done), .mem_re(mem_re), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rdata(mem_rdata), .en(en), .w_out(w_out));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: row word identifies address and lane; data appears one cycle after issue.
  function automatic logic [DW-1:0] row_word(logic [AW-1:0] a, int j);
    logic [3:0] l;
    l = j[3:0];
    return {2'b00, a, l};
  endfunction

  logic [AW-1:0] rd_addr = '0;
  always @(posedge clk) if (mem_re && mem_gnt) rd_addr <= mem_addr;
  always_comb begin
    for (int j = 0; j < FW; j++) mem_rdata[j] = row_word(rd_addr, j);
  end

  int gnt_mode = 0;
  initial begin
    mem_gnt = 1'b1;
    forever begin
      @(posedge clk); #1;
      mem_gnt = (gnt_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end
  end

  typedef struct { bit is_done; logic [AW-1:0] addr; logic [FW-1:0] mask; } push_t;
  logic [AW-1:0] iss_q[$];
  push_t         push_q[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit wout_zero();
    for (int j = 0; j < FW; j++) if (w_out[j] !== '0) return 1'b0;
    return 1'b1;
  endfunction

  // Monitor state
  int  done_cnt = 0;
  int  en_first = -1, en_last = -1, re_fall = -1;
  int  re_rise_q[$], done_cyc_q[$], busy_fall_q[$];
  bit  prev_re = 0, prev_busy = 0, prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (mem_re === 1'b1 && mem_gnt === 1'b1) begin
      check("issue_expected", iss_q.size() > 0, 1);
      if (iss_q.size() > 0) check("issue_addr", mem_addr, iss_q.pop_front());
    end
    if (prev_stall) begin
      check("stall_re_held", mem_re, 1);
      check("stall_addr_held", mem_addr, prev_addr);
    end
    if (en !== '0 || !wout_zero()) begin
      check("push_expected", push_q.size() > 0 && !push_q[0].is_done, 1);
      if (push_q.size() > 0 && !push_q[0].is_done) begin
        push_t p;
        p = push_q.pop_front();
        check("push_en", en, p.mask);
        for (int j = 0; j < FW; j++) check("push_w_out", w_out[j], row_word(p.addr, j));
      end
    end
    if (done === 1'b1) begin
      check("done_expected", push_q.size() > 0 && push_q[0].is_done, 1);
      if (push_q.size() > 0 && push_q[0].is_done) void'(push_q.pop_front());
      done_cnt++;
      done_cyc_q.push_back(cyc);
    end
    if (en !== '0) begin
      if (en_first < 0) en_first = cyc;
      en_last = cyc;
    end
    if (mem_re === 1'b1 && !prev_re) re_rise_q.push_back(cyc);
    if (mem_re !== 1'b1 && prev_re) re_fall = cyc;
    if (busy !== 1'b1 && prev_busy) busy_fall_q.push_back(cyc);
    prev_re    = (mem_re === 1'b1);
    prev_busy  = (busy === 1'b1);
    prev_stall = (mem_re === 1'b1) && (mem_gnt !== 1'b1);
    prev_addr  = mem_addr;
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    en_first = -1; en_last = -1; re_fall = -1;
    re_rise_q.delete(); done_cyc_q.delete(); busy_fall_q.delete();
  endtask

  task automatic expect_load(logic [AW-1:0] base, logic [FW-1:0] mask, int n_iss, int n_push, bit with_done);
    push_t p;
    for (int k = 0; k < n_iss; k++) iss_q.push_back(AW'(base + AW'(k)));
    for (int k = 0; k < n_push; k++) begin
      p.is_done = 0; p.addr = AW'(base + AW'(k)); p.mask = mask;
      push_q.push_back(p);
    end
    if (with_done) begin
      p.is_done = 1; p.addr = '0; p.mask = '0;
      push_q.push_back(p);
    end
  endtask

  task automatic do_start(logic [AW-1:0] base, logic [FW-1:0] mask, output int t0);
    base_addr = base; col_mask = mask; start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(string name, int budget);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < budget) begin tick(); n++; end
    check(name, done_cnt > d0, 1);
  endtask

  task automatic settle_check(string name);
    tick(3);
    check({name, "_busy_low"}, busy, 0);
    check({name, "_issues_left"}, iss_q.size(), 0);
    check({name, "_pushes_left"}, push_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0, d0;
    rst = 1'b1; start = 1'b0; base_addr = '0; col_mask = '0;
    tick(3);
    rst = 1'b0;
    tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_mem_re", mem_re, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_en", en, 0);
    check("reset_w_out_zero", wout_zero(), 1);

    // 1: nominal load, gnt always high, exact timing
    clear_rec();
    expect_load(10'h010, 16'hFFFF, FD, FD, 1);
    do_start(10'h010, 16'hFFFF, t0);
    wait_done("t1_done_seen", 60);
    tick(2);
    check("t1_re_first", re_rise_q.size() > 0 ? re_rise_q[0] - t0 : -1, 1);
    check("t1_re_fall", re_fall - t0, 17);
    check("t1_en_first", en_first - t0, 2);
    check("t1_en_last", en_last - t0, 17);
    check("t1_done_cycle", done_cyc_q.size() > 0 ? done_cyc_q[0] - t0 : -1, 18);
    check("t1_busy_fall", busy_fall_q.size() > 0 ? busy_fall_q[0] - t0 : -1, 19);
    settle_check("t1");

    // 2: grant stalls 1,0,0,...
    clear_rec();
    gnt_mode = 1;
    d0 = done_cnt;
    expect_load(10'h123, 16'hA5C3, FD, FD, 1);
    do_start(10'h123, 16'hA5C3, t0);
    wait_done("t2_done_seen", 300);
    settle_check("t2");
    check("t2_single_done", done_cnt - d0, 1);
    gnt_mode = 0;
    tick(2);

    // 3: address wrap
    clear_rec();
    expect_load(10'h3FC, 16'hFFFF, FD, FD, 1);
    do_start(10'h3FC, 16'hFFFF, t0);
    wait_done("t3_done_seen", 60);
    settle_check("t3");

    // 4: latched mask, start pulses during busy ignored
    clear_rec();
    d0 = done_cnt;
    expect_load(10'h200, 16'h00F0, FD, FD, 1);
    do_start(10'h200, 16'h00F0, t0);
    tick(2);
    col_mask = 16'hFFFF; base_addr = 10'h300; start = 1'b1;
    tick();
    start = 1'b0;
    tick(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4_done_seen", 60);
    tick(20);
    check("t4_single_load", re_rise_q.size(), 1);
    check("t4_single_done", done_cnt - d0, 1);
    settle_check("t4");

    // 4b: col_mask = 0 still reads and completes, en never set
    clear_rec();
    expect_load(10'h050, 16'h0000, FD, FD, 1);
    do_start(10'h050, 16'h0000, t0);
    wait_done("t4b_done_seen", 60);
    check("t4b_en_never", en_first, -1);
    settle_check("t4b");

    // 5: reset at cycle 8 of a load, then a clean load
    clear_rec();
    d0 = done_cnt;
    expect_load(10'h0A0, 16'hFFFF, 8, 7, 0);
    do_start(10'h0A0, 16'hFFFF, t0);
    tick(7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_mem_re", mem_re, 0);
    check("t5_rst_mem_addr", mem_addr, 0);
    check("t5_rst_en", en, 0);
    check("t5_rst_w_out_zero", wout_zero(), 1);
    settle_check("t5_abort");
    check("t5_no_done", done_cnt - d0, 0);
    clear_rec();
    expect_load(10'h3F8, 16'h5A5A, FD, FD, 1);
    do_start(10'h3F8, 16'h5A5A, t0);
    wait_done("t5_restart_done", 60);
    settle_check("t5_restart");

    // 6: start held high, back-to-back loads with one IDLE cycle between
    clear_rec();
    expect_load(10'h040, 16'h0FF0, FD, FD, 1);
    expect_load(10'h040, 16'h0FF0, FD, FD, 1);
    base_addr = 10'h040; col_mask = 16'h0FF0; start = 1'b1; t0 = cyc;
    tick(21);
    start = 1'b0;
    wait_done("t6_second_done", 60);
    check("t6_two_loads", re_rise_q.size(), 2);
    check("t6_first_done", done_cyc_q.size() > 0 ? done_cyc_q[0] - t0 : -1, 18);
    check("t6_second_start", re_rise_q.size() > 1 ? re_rise_q[1] - t0 : -1, 20);
    check("t6_idle_gap", (re_rise_q.size() > 1 && busy_fall_q.size() > 0) ? re_rise_q[1] - busy_fall_q[0] : -1, 1);
    settle_check("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
